// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared scanner types: FSM states, column selects, key encoding.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    function automatic logic [3:0] key_encode(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

    function automatic logic [3:0] col_onehot(input logic [1:0] col_idx);
        case (col_idx)
            2'd0:    return COL0;
            2'd1:    return COL1;
            2'd2:    return COL2;
            default: return COL3;
        endcase
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchronizer for the active-low keypad row lines.
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_row,
    output logic [3:0] o_row_s
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Idle rows read high, so reset to "no key" rather than zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 4'b1111;
            r_sync <= 4'b1111;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row_s = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner: tick divider, scan/debounce FSM, key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_W   = 16,
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] DEB_LIM = 4'(DEB_TICKS);

    logic [3:0]            w_row_s;
    logic [SCAN_DIV_W-1:0] r_div;
    logic                  w_tick;
    logic                  w_any_low;
    logic                  w_hit;
    logic                  w_deb_done;
    logic                  w_accept;
    logic                  w_release;
    logic [1:0]            w_low_idx;
    logic [3:0]            w_deb_inc;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_col_idx;
    logic [1:0]            w_col_nxt;
    logic [1:0]            r_row_idx;
    logic [1:0]            w_row_nxt;
    logic [3:0]            r_deb_cnt;
    logic [3:0]            w_deb_nxt;
    logic [3:0]            r_key_code;
    logic [3:0]            w_code_nxt;
    logic                  r_key_valid;
    logic                  w_valid_nxt;
    logic                  r_key_held;
    logic                  w_held_nxt;

`ifdef KEYPAD_REPEAT_EN
    localparam int             RPT_W   = $clog2(REPEAT_TICKS + 1);
    localparam logic [RPT_W-1:0] RPT_LIM = RPT_W'(REPEAT_TICKS);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_nxt;
    logic [RPT_W-1:0] w_rpt_inc;

    assign w_rpt_inc = r_rpt_cnt + RPT_W'(1);
`endif

    keypad_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_row   (row),
        .o_row_s (w_row_s)
    );

    assign w_tick     = &r_div;
    assign w_any_low  = ~&w_row_s;
    assign w_hit      = ~w_row_s[r_row_idx];
    assign w_deb_inc  = r_deb_cnt + 4'd1;
    assign w_deb_done = (w_deb_inc >= DEB_LIM);

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        w_low_idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!w_row_s[i]) w_low_idx = 2'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_idx;
        w_row_nxt   = r_row_idx;
        w_deb_nxt   = r_deb_cnt;
        w_code_nxt  = r_key_code;
        w_valid_nxt = 1'b0;
        w_held_nxt  = r_key_held;
        w_accept    = 1'b0;
        w_release   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rpt_nxt   = r_rpt_cnt;
`endif
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_any_low) begin
                        w_row_nxt = w_low_idx;
                        w_deb_nxt = 4'd1;
                        if (DEB_LIM <= 4'd1) w_accept = 1'b1;
                        else                 w_state_nxt = DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_hit) begin
                        if (w_deb_done) w_accept = 1'b1;
                        else            w_deb_nxt = w_deb_inc;
                    end else begin
                        w_state_nxt = SCAN;
                        w_col_nxt   = r_col_idx + 2'd1;
                        w_deb_nxt   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (!w_hit) begin
                        w_deb_nxt = 4'd1;
`ifdef KEYPAD_REPEAT_EN
                        w_rpt_nxt = '0;
`endif
                        if (DEB_LIM <= 4'd1) w_release = 1'b1;
                        else                 w_state_nxt = RELEASE;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (w_rpt_inc == RPT_LIM) begin
                            w_valid_nxt = 1'b1;
                            w_rpt_nxt   = '0;
                        end else begin
                            w_rpt_nxt = w_rpt_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (!w_hit) begin
                        if (w_deb_done) w_release = 1'b1;
                        else            w_deb_nxt = w_deb_inc;
                    end else begin
                        w_state_nxt = PRESSED;
                        w_deb_nxt   = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                        w_rpt_nxt   = '0;
`endif
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end
        if (w_accept) begin
            w_state_nxt = PRESSED;
            w_code_nxt  = key_encode(w_row_nxt, r_col_idx);
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
            w_deb_nxt   = 4'd0;
`ifdef KEYPAD_REPEAT_EN
            w_rpt_nxt   = '0;
`endif
        end
        // A finished release resumes scanning at the column after the released key.
        if (w_release) begin
            w_state_nxt = SCAN;
            w_held_nxt  = 1'b0;
            w_col_nxt   = r_col_idx + 2'd1;
            w_deb_nxt   = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_state     <= SCAN;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_deb_cnt   <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rpt_cnt   <= '0;
`endif
        end else begin
            r_div       <= r_div + SCAN_DIV_W'(1);
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_nxt;
            r_row_idx   <= w_row_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_held  <= w_held_nxt;
`ifdef KEYPAD_REPEAT_EN
            r_rpt_cnt   <= w_rpt_nxt;
`endif
        end
    end

    assign col       = col_onehot(r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - keypad scanner bench: emulated key matrix, tick-level reference model.
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int RPT = 5;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV_W   (2),
        .DEB_TICKS    (DEB),
        .REPEAT_TICKS (RPT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Pressed key (r,c) shorts row r to column c: row reads low while that column is selected.
    function automatic logic [3:0] pad_rows(input logic [3:0] c, input logic [15:0] k);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (!c[cc] && k[r*4+cc]) rows[r] = 1'b0;
        return rows;
    endfunction

    function automatic logic [3:0] col_of(input int idx);
        logic [3:0] one;
        one = 4'b0001 << idx;
        return ~one;
    endfunction

    always_comb row = pad_rows(col, keys);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: phase 0 idle scan, 1 confirming press, 2 key down, 3 confirming release.
    int         m_cyc, m_ph, m_col, m_row, m_cnt, m_rpt;
    logic [3:0] m_code, m_h1, m_h2;
    logic       m_valid, m_held;

    task model_accept();
        m_ph    = 2;
        m_code  = 4'(m_row * 4 + m_col);
        m_valid = 1'b1;
        m_held  = 1'b1;
        m_rpt   = 0;
    endtask

    task model_release();
        m_ph   = 0;
        m_held = 1'b0;
        m_col  = (m_col + 1) % 4;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_ph = 0; m_col = 0; m_row = 0; m_cnt = 0; m_rpt = 0;
            m_code = 4'h0; m_h1 = 4'hF; m_h2 = 4'hF; m_valid = 1'b0; m_held = 1'b0;
        end else begin
            logic [3:0] rs;
            rs      = m_h2;
            m_h2    = m_h1;
            m_h1    = pad_rows(col_of(m_col), keys);
            m_valid = 1'b0;
            if (m_cyc % DIV == DIV - 1) begin
                case (m_ph)
                    0: if (rs != 4'hF) begin
                           for (int r = 3; r >= 0; r--) if (!rs[r]) m_row = r;
                           m_cnt = 1;
                           m_ph  = 1;
                           if (m_cnt >= DEB) model_accept();
                       end else m_col = (m_col + 1) % 4;
                    1: if (!rs[m_row]) begin
                           m_cnt++;
                           if (m_cnt >= DEB) model_accept();
                       end else begin
                           m_ph  = 0;
                           m_col = (m_col + 1) % 4;
                       end
                    2: if (rs[m_row]) begin
                           m_cnt = 1;
                           m_ph  = 3;
                           m_rpt = 0;
                           if (m_cnt >= DEB) model_release();
                       end else begin
`ifdef KEYPAD_REPEAT_EN
                           m_rpt++;
                           if (m_rpt == RPT) begin
                               m_valid = 1'b1;
                               m_rpt   = 0;
                           end
`endif
                       end
                    default: if (rs[m_row]) begin
                           m_cnt++;
                           if (m_cnt >= DEB) model_release();
                       end else begin
                           m_ph  = 2;
                           m_rpt = 0;
                       end
                endcase
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check_eq("col", col, col_of(m_col));
            check_eq("key_valid", key_valid, m_valid);
            check_eq("key_held", key_held, m_held);
            check_eq("key_code", key_code, m_code);
            if (key_valid) n_valid++;
        end
    end

    task automatic ticks(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic wait_held(input int budget);
        int n;
        n = 0;
        while (!key_held && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_held", key_held, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] saved;
        int          k;
        int          hold;

        repeat (3) @(negedge clk);
        check_eq("rst_col", col, 4'b1110);
        check_eq("rst_valid", key_valid, 1'b0);
        check_eq("rst_held", key_held, 1'b0);
        check_eq("rst_code", key_code, 4'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle scanning
        n_valid = 0;
        ticks(8);
        check_eq("idle_valid_cnt", n_valid, 0);
        check_eq("idle_held", key_held, 1'b0);

        // Long hold of key row 2 / column 2
        keys    = 16'h1 << 10;
        n_valid = 0;
        ticks(24);
`ifndef KEYPAD_REPEAT_EN
        check_eq("hold_valid_cnt", n_valid, 1);
`endif
        check_eq("hold_code", key_code, 4'd10);
        check_eq("hold_held", key_held, 1'b1);
        check_eq("hold_col", col, 4'b1011);
        keys = 16'h0;
        ticks(6);
        check_eq("hold_released", key_held, 1'b0);

        // Bounce: row 1 low for a single tick in column 0
        reset = 1'b1;
        keys  = 16'h1 << 4;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        n_valid = 0;
        repeat (4) @(negedge clk);
        check_eq("bounce_frozen", col, 4'b1110);
        @(negedge clk);
        keys = 16'h0;
        repeat (3) @(negedge clk);
        check_eq("bounce_col", col, 4'b1101);
        ticks(3);
        check_eq("bounce_valid_cnt", n_valid, 0);
        check_eq("bounce_held", key_held, 1'b0);

        // Release glitch of two ticks while pressed
        keys = 16'h1 << 5;
        wait_held(100);
        @(negedge clk);
        n_valid = 0;
        keys    = 16'h0;
        repeat (8) @(negedge clk);
        keys = 16'h1 << 5;
        ticks(4);
        check_eq("glitch_held", key_held, 1'b1);
        check_eq("glitch_valid_cnt", n_valid, 0);
        keys = 16'h0;
        ticks(6);
        check_eq("glitch_released", key_held, 1'b0);

        // Two keys in column 3: row 0 wins
        keys = (16'h1 << 3) | (16'h1 << 15);
        wait_held(100);
        check_eq("two_key_code", key_code, 4'd3);
        keys = 16'h0;
        ticks(6);

        // Long hold (auto-repeat when enabled), then reset mid-hold
        keys = 16'h1 << 6;
        wait_held(100);
        @(negedge clk);
        n_valid = 0;
        ticks(17);
`ifdef KEYPAD_REPEAT_EN
        check_eq("repeat_cnt", n_valid, 3);
`else
        check_eq("repeat_cnt", n_valid, 0);
`endif
        #2;
        reset = 1'b1;
        #1;
        check_eq("midhold_rst_col", col, 4'b1110);
        check_eq("midhold_rst_held", key_held, 1'b0);
        check_eq("midhold_rst_valid", key_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        wait_held(100);
        check_eq("refresh_code", key_code, 4'd6);
        keys = 16'h0;
        ticks(6);

        // Randomized presses, overlapping keys and release glitches
        for (int i = 0; i < 30; i++) begin
            k    = $urandom_range(15, 0);
            keys = 16'h1 << k;
            if ($urandom_range(3, 0) == 0) keys = keys | (16'h1 << $urandom_range(15, 0));
            hold = $urandom_range(40, 4);
            for (int t = 0; t < hold; t++) begin
                if ($urandom_range(15, 0) == 0) begin
                    saved = keys;
                    keys  = 16'h0;
                    repeat ($urandom_range(10, 1)) @(negedge clk);
                    keys = saved;
                end
                repeat (DIV) @(negedge clk);
            end
            keys = 16'h0;
            repeat ($urandom_range(40, 1)) @(negedge clk);
        end
        ticks(6);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

4×4 matrix keypad scanner for the board's user-input port; the input-side counterpart of the multiplexed four-digit display driver. The keypad side uses the same active-low, one-hot, time-multiplexed select scheme as the display anodes, but the block reads row lines back instead of driving segments. It debounces a single key and emits a 4-bit key code with a one-cycle valid strobe. It sits between the keypad pins and the application logic, for example the animation or mode selector.

## Interface
- SCAN_DIV_W, 16: scan tick period is 2^SCAN_DIV_W clk cycles.
- DEB_TICKS, 4: consecutive matching ticks required to accept a press or a release (1..15).
- REPEAT_TICKS, 50: auto-repeat period in ticks. Used only with KEYPAD_REPEAT_EN.
- clk  input  1  system clock, the only clock.
- reset  input  1  asynchronous, active-high reset.
- row  input  4  keypad row lines, active-low; asynchronous to clk.
- col  output  4  column select, active-low one-hot.
- key_code  output  4  code of the last accepted key, = row_idx*4 + col_idx.
- key_valid  output  1  one-clk pulse per accepted press (and per repeat).
- key_held  output  1  high from acceptance until release is accepted.

## Operation
- row passes through a 2-flop synchronizer, giving row_s. All decisions use row_s.
- A free-running SCAN_DIV_W-bit divider produces tick: a 1-clk pulse when the divider wraps to 0.
- FSM states are SCAN, DEBOUNCE, PRESSED and RELEASE.
- SCAN:
  - col rotates 1110→1101→1011→0111→1110 on each tick (col_idx 0→1→2→3→0).
  - On a tick, if any row_s bit is 0, capture the lowest-index low row as row_idx and the current col_idx. Go to DEBOUNCE with deb_cnt=1, col frozen.
- DEBOUNCE:
  - On each tick where row_s[row_idx]==0, increment deb_cnt.
  - When deb_cnt reaches DEB_TICKS, go to PRESSED.
  - A tick with row_s[row_idx]==1 returns to SCAN, advances col, and sets deb_cnt=0.
- PRESSED:
  - On entry, key_code is loaded and key_valid pulses and key_held sets, all in the same clk.
  - col stays frozen.
  - On a tick with row_s[row_idx]==1, go to RELEASE with deb_cnt=1.
- RELEASE:
  - On each tick where row_s[row_idx]==1, increment deb_cnt.
  - When deb_cnt reaches DEB_TICKS, clear key_held and go to SCAN. col advances to the next column.
  - A tick with row_s[row_idx]==0 returns to PRESSED with no new key_valid.
- Other keys pressed while in DEBOUNCE, PRESSED or RELEASE are ignored (no rollover).
- Multiple low rows in one sampled column: the lowest row index wins.
- key_code holds its value until the next accepted press.

## Timing
- Reset values:
  - col=4'b1110, key_code=0, key_valid=0, key_held=0.
  - State SCAN; divider, deb_cnt and rpt_cnt all 0.
- Reset is asynchronous, so it takes effect mid-debounce or mid-hold immediately. After release, scanning restarts at column 0 with no pulse.
- Input latency: a row edge is visible in row_s 2 clk later and is sampled only on ticks.
- Press-to-strobe latency: key_valid rises 1 clk after the tick on which deb_cnt reaches DEB_TICKS. That is DEB_TICKS−1 ticks after the capture tick, plus 1 clk.
- key_held falls 1 clk after the tick on which the release count reaches DEB_TICKS.
- A key held through reset deassertion is captured again as a fresh press.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, rpt_cnt counts ticks from entry. Each time it reaches REPEAT_TICKS, key_valid pulses for 1 clk and rpt_cnt clears.
  - rpt_cnt clears on entry to RELEASE and on return from RELEASE to PRESSED.
- KEYPAD_REPEAT_EN undefined: rpt_cnt and the REPEAT_TICKS logic are absent, and exactly one key_valid pulse occurs per press.

## Structure
- Package keypad_pkg holds:
  - the FSM state enum (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - the column one-hot constants (COL0=4'b1110 … COL3=4'b0111);
  - the key_code encoding function (row_idx, col_idx).
- One sub-module: keypad_sync, the 2-flop synchronizer on row with async reset to 4'b1111.
- The divider, FSM and counters live in keypad_scanner.

## Test plan
All scenarios use SCAN_DIV_W=2 (tick every 4 clk) and DEB_TICKS=3.
- Reset, no keys:
  - col cycles 1110,1101,1011,0111 every 4 clk.
  - key_valid stays 0 and key_held stays 0.
- Hold row[2]=0 whenever col==1011 for 20 ticks:
  - exactly one key_valid with key_code=10 (2*4+2);
  - key_held=1 while held; col frozen at 1011.
- Bounce: row[1] low for 1 tick, then high, during col==1110. The bench returns to SCAN with no key_valid and col advances to 1101.
- Release glitch: in PRESSED, row high for 2 ticks, then low again. The bench returns to PRESSED, key_held stays 1, and no new key_valid occurs.
- Two keys, row[0] and row[3], low in column 3: key_code=3, and row[3] is ignored.
- With KEYPAD_REPEAT_EN and REPEAT_TICKS=5, hold the key for 17 ticks after acceptance: 1+3 key_valid pulses, 5 ticks apart. Assert reset mid-hold: col=1110 and key_held=0 immediately.
